// File: rtl/dual_b_load_sched.sv
// dual_b_load_sched
// Sequencer for the DSP48E1 dual B register. It preloads two coefficients
// (B2 gets the first one, B1 the second), then alternates INMODE[4] for
// RUN_LEN multiplier transfers, so the multiplier sees B2, B1, B2, ...
//
// Optional feature: define DUAL_B_ABORT_EN to add an 'abort' input. When it
// is high in LOAD2 or RUN, the sequencer returns to IDLE on the next edge
// without a done pulse.
//
// CEB1, CEB2 and B_out are Mealy outputs. The B register therefore captures
// on the same edge as the s_valid/s_ready handshake.
// RUN_LEN must lie in 1 .. 2**CNT_W. The run counter never wraps.

module dual_b_load_sched #(
    parameter int B_WIDTH = 18,
    parameter int RUN_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               s_valid,
    input  logic [B_WIDTH-1:0] s_data,
    output logic               s_ready,
    output logic [B_WIDTH-1:0] B_out,
    output logic               CEB1,
    output logic               CEB2,
    output logic               inmode4,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               done
`ifdef DUAL_B_ABORT_EN
    ,
    input  logic               abort
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD2 = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Count value of the final transfer of a run.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RUN_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             phase_q, phase_d;
    logic             done_q,  done_d;
    logic             abort_w;

`ifdef DUAL_B_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign done = done_q;

    // Next-state and output decode. Reset forces every combinational output low.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
        state_d = state_q;
        count_d = count_q;
        phase_d = phase_q;
        done_d  = 1'b0;
        s_ready = 1'b0;
        B_out   = '0;
        CEB1    = 1'b0;
        CEB2    = 1'b0;
        inmode4 = 1'b0;
        m_valid = 1'b0;

        if (!RST) begin
            unique case (state_q)
                ST_IDLE: begin
                    // Abort is meaningless here; the first coefficient goes into B1.
                    s_ready = 1'b1;
                    B_out   = s_data;
                    if (s_valid) begin
                        CEB1    = 1'b1;
                        state_d = ST_LOAD2;
                    end
                end

                ST_LOAD2: begin
                    if (abort_w) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                        phase_d = 1'b0;
                    end else begin
                        s_ready = 1'b1;
                        B_out   = s_data;
                        if (s_valid) begin
                            // Both stages are enabled, so B2 <= B1 (coef0) and B1 <= coef1.
                            CEB1    = 1'b1;
                            CEB2    = 1'b1;
                            state_d = ST_RUN;
                            count_d = '0;
                            phase_d = 1'b0;
                        end
                    end
                end

                ST_RUN: begin
                    if (abort_w) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                        phase_d = 1'b0;
                    end else begin
                        m_valid = 1'b1;
                        inmode4 = phase_q;
                        if (m_ready) begin
                            if (count_q == LAST_CNT) begin
                                state_d = ST_IDLE;
                                count_d = '0;
                                phase_d = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                count_d = count_q + CNT_W'(1);
                                phase_d = ~phase_q;
                            end
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    phase_d = 1'b0;
                end
            endcase
        end
    end

    // State, run counter, B select phase and done pulse register, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
        if (RST) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            phase_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            phase_q <= phase_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_dual_b_load_sched.sv
// Bench for dual_b_load_sched (RUN_LEN=4).
// The reference model tracks the number of coefficients loaded, the number of
// transfers completed and the stored coefficient pair. A model of the dual B
// register is driven by the DUT enables and is used to check the multiplier
// operand. A negedge scoreboard compares every output on every cycle. The
// scenario tasks add directed checks from the test plan.

module tb_dual_b_load_sched;

    localparam int BW      = 18;
    localparam int RUN_LEN = 4;

    logic          clk = 1'b0;
    logic          RST;
    logic          s_valid;
    logic [BW-1:0] s_data;
    logic          s_ready;
    logic [BW-1:0] B_out;
    logic          CEB1, CEB2, inmode4, m_valid, m_ready, done;
    logic          abort = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dual_b_load_sched #(.B_WIDTH(BW), .RUN_LEN(RUN_LEN), .CNT_W(8)) u_dut (
        .clk     (clk),
        .RST     (RST),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .B_out   (B_out),
        .CEB1    (CEB1),
        .CEB2    (CEB2),
        .inmode4 (inmode4),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .done    (done)
`ifdef DUAL_B_ABORT_EN
        ,
        .abort   (abort)
`endif
    );

    // ---------------- reference model ----------------
    int            m_loaded = 0;   // coefficients accepted in the current pair (0..2)
    int            m_xfers  = 0;   // transfers completed in the current run
    logic          m_done   = 1'b0;
    logic [BW-1:0] m_c0 = '0, m_c1 = '0;
    logic [BW-1:0] reg_b1 = '0, reg_b2 = '0;   // dual B register model
    logic          smp_ceb1 = 1'b0, smp_ceb2 = 1'b0;
    logic [BW-1:0] smp_bout = '0;

    function automatic logic model_abort();
`ifdef DUAL_B_ABORT_EN
        return abort && (m_loaded > 0) && !RST;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        if (RST) begin
            m_loaded = 0;
            m_xfers  = 0;
            m_done   = 1'b0;
        end else if (model_abort()) begin
            m_loaded = 0;
            m_xfers  = 0;
            m_done   = 1'b0;
        end else begin
            m_done = (m_loaded == 2) && m_ready && (m_xfers == RUN_LEN - 1);
            if (m_loaded < 2) begin
                if (s_valid) begin
                    if (m_loaded == 0) m_c0 = s_data;
                    else               m_c1 = s_data;
                    m_loaded++;
                end
            end else if (m_ready) begin
                m_xfers++;
                if (m_xfers == RUN_LEN) begin
                    m_loaded = 0;
                    m_xfers  = 0;
                end
            end
        end
        if (smp_ceb2) reg_b2 = reg_b1;
        if (smp_ceb1) reg_b1 = smp_bout;
    end

    // Scoreboard: compare every output against the model away from the active edge.
    always @(negedge clk) begin
        logic          e_sr, e_c1, e_c2, e_mv, e_im;
        logic [BW-1:0] e_bo, e_op, op;
        e_sr = !RST && (m_loaded < 2) && !model_abort();
        e_mv = !RST && (m_loaded == 2) && !model_abort();
        e_c1 = e_sr && s_valid;
        e_c2 = e_sr && s_valid && (m_loaded == 1);
        e_bo = e_sr ? s_data : '0;
        e_im = e_mv && ((m_xfers % 2) == 1);
        if (s_ready !== e_sr) begin bad++; $display("FAIL mon_s_ready t=%0t got=%b exp=%b", $time, s_ready, e_sr); end
        total++;
        if (CEB1 !== e_c1) begin bad++; $display("FAIL mon_ceb1 t=%0t got=%b exp=%b", $time, CEB1, e_c1); end
        total++;
        if (CEB2 !== e_c2) begin bad++; $display("FAIL mon_ceb2 t=%0t got=%b exp=%b", $time, CEB2, e_c2); end
        total++;
        if (B_out !== e_bo) begin bad++; $display("FAIL mon_b_out t=%0t got=%h exp=%h", $time, B_out, e_bo); end
        total++;
        if (m_valid !== e_mv) begin bad++; $display("FAIL mon_m_valid t=%0t got=%b exp=%b", $time, m_valid, e_mv); end
        total++;
        if (inmode4 !== e_im) begin bad++; $display("FAIL mon_inmode4 t=%0t got=%b exp=%b", $time, inmode4, e_im); end
        total++;
        if (done !== m_done) begin bad++; $display("FAIL mon_done t=%0t got=%b exp=%b", $time, done, m_done); end
        total++;
        if (e_mv) begin
            op   = inmode4 ? reg_b1 : reg_b2;
            e_op = ((m_xfers % 2) == 1) ? m_c1 : m_c0;
            if (op !== e_op) begin bad++; $display("FAIL mon_operand t=%0t got=%h exp=%h", $time, op, e_op); end
            total++;
        end
        smp_ceb1 = CEB1;
        smp_ceb2 = CEB2;
        smp_bout = B_out;
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic rst, input logic sv, input logic [BW-1:0] sd, input logic mr);
        RST     = rst;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pair(input logic [BW-1:0] c0, input logic [BW-1:0] c1);
        drive(0, 1, c0, 0); next_cycle();
        drive(0, 1, c1, 0); next_cycle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(1, 1, 18'h2AAAA, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if ({s_ready, CEB1, CEB2, m_valid, inmode4, done} !== 6'b0) begin
                bad++;
                $display("FAIL reset_outputs cyc=%0d got=%b exp=000000", i,
                         {s_ready, CEB1, CEB2, m_valid, inmode4, done});
            end
            total++;
            next_cycle();
        end
        drive(0, 0, '0, 0);
        @(negedge clk);
        if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_release_s_ready got=%b exp=1", s_ready); end
        total++;
        next_cycle();
    endtask

    task automatic test_basic();
        logic [BW-1:0] op, e_op;
        drive(0, 1, 18'h00011, 0);
        @(negedge clk);
        if ({CEB1, CEB2} !== 2'b10) begin bad++; $display("FAIL basic_load1_ceb got=%b exp=10", {CEB1, CEB2}); end
        total++;
        if (B_out !== 18'h00011) begin bad++; $display("FAIL basic_load1_b_out got=%h exp=00011", B_out); end
        total++;
        next_cycle();
        drive(0, 1, 18'h00022, 0);
        @(negedge clk);
        if ({CEB1, CEB2} !== 2'b11) begin bad++; $display("FAIL basic_load2_ceb got=%b exp=11", {CEB1, CEB2}); end
        total++;
        if (B_out !== 18'h00022) begin bad++; $display("FAIL basic_load2_b_out got=%h exp=00022", B_out); end
        total++;
        next_cycle();
        for (int i = 0; i < RUN_LEN; i++) begin
            drive(0, 0, '0, 1);
            @(negedge clk);
            e_op = (i % 2 == 1) ? 18'h00022 : 18'h00011;
            op   = inmode4 ? reg_b1 : reg_b2;
            if (m_valid !== 1'b1) begin bad++; $display("FAIL basic_run_m_valid i=%0d got=%b exp=1", i, m_valid); end
            total++;
            if (inmode4 !== (i % 2 == 1)) begin bad++; $display("FAIL basic_run_inmode4 i=%0d got=%b exp=%0d", i, inmode4, i % 2); end
            total++;
            if (op !== e_op) begin bad++; $display("FAIL basic_run_operand i=%0d got=%h exp=%h", i, op, e_op); end
            total++;
            next_cycle();
        end
        drive(0, 0, '0, 0);
        @(negedge clk);
        if ({done, s_ready} !== 2'b11) begin bad++; $display("FAIL basic_done got done,s_ready=%b exp=11", {done, s_ready}); end
        total++;
        next_cycle();
    endtask

    task automatic test_stall();
        int run_cycles = 0;
        int dones      = 0;
        load_pair(BW'($urandom), BW'($urandom));
        for (int cyc = 0; cyc < 12; cyc++) begin
            drive(0, 0, '0, !(cyc >= 1 && cyc <= 3));
            @(negedge clk);
            if (m_valid === 1'b1) run_cycles++;
            if (done === 1'b1) dones++;
            if (cyc >= 1 && cyc <= 3) begin
                if ({m_valid, inmode4} !== 2'b11) begin
                    bad++; $display("FAIL stall_hold cyc=%0d got m_valid,inmode4=%b exp=11", cyc, {m_valid, inmode4});
                end
                total++;
            end
            next_cycle();
        end
        if (run_cycles != 7) begin bad++; $display("FAIL stall_run_length got=%0d exp=7", run_cycles); end
        total++;
        if (dones != 1) begin bad++; $display("FAIL stall_done_count got=%0d exp=1", dones); end
        total++;
    endtask

    task automatic test_load_gap();
        drive(0, 1, BW'($urandom), 0); next_cycle();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, BW'($urandom), 1);
            @(negedge clk);
            if ({CEB1, CEB2, s_ready, m_valid} !== 4'b0010) begin
                bad++; $display("FAIL gap_wait i=%0d got ceb1,ceb2,s_ready,m_valid=%b exp=0010", i, {CEB1, CEB2, s_ready, m_valid});
            end
            total++;
            next_cycle();
        end
        drive(0, 1, BW'($urandom), 0);
        @(negedge clk);
        if ({CEB1, CEB2} !== 2'b11) begin bad++; $display("FAIL gap_load2_ceb got=%b exp=11", {CEB1, CEB2}); end
        total++;
        next_cycle();
        for (int i = 0; i < RUN_LEN; i++) begin drive(0, 0, '0, 1); next_cycle(); end
        drive(0, 0, '0, 0);
        @(negedge clk);
        if (done !== 1'b1) begin bad++; $display("FAIL gap_done got=%b exp=1", done); end
        total++;
        next_cycle();
    endtask

    task automatic test_run_ignore();
        logic [BW-1:0] c_next;
        load_pair(BW'($urandom), BW'($urandom));
        for (int i = 0; i < RUN_LEN; i++) begin
            drive(0, 1, 18'h3FFFF, 1);
            @(negedge clk);
            if ({s_ready, CEB1, CEB2} !== 3'b000 || B_out !== '0) begin
                bad++; $display("FAIL ignore_run i=%0d got s_ready,ceb1,ceb2=%b b_out=%h exp 000 00000", i, {s_ready, CEB1, CEB2}, B_out);
            end
            total++;
            next_cycle();
        end
        // Done cycle doubles as the first load of the next pair.
        c_next = BW'($urandom);
        drive(0, 1, c_next, 0);
        @(negedge clk);
        if ({done, s_ready, CEB1, CEB2} !== 4'b1110) begin
            bad++; $display("FAIL b2b_done_load got done,s_ready,ceb1,ceb2=%b exp=1110", {done, s_ready, CEB1, CEB2});
        end
        total++;
        if (B_out !== c_next) begin bad++; $display("FAIL b2b_b_out got=%h exp=%h", B_out, c_next); end
        total++;
        next_cycle();
    endtask

    task automatic test_back_to_back();
        // Continues from LOAD2 left by test_run_ignore.
        drive(0, 1, BW'($urandom), 0);
        @(negedge clk);
        if ({CEB1, CEB2} !== 2'b11) begin bad++; $display("FAIL b2b_load2_ceb got=%b exp=11", {CEB1, CEB2}); end
        total++;
        next_cycle();
        for (int i = 0; i < RUN_LEN; i++) begin drive(0, 0, '0, 1); next_cycle(); end
        drive(0, 0, '0, 0);
        @(negedge clk);
        if (done !== 1'b1) begin bad++; $display("FAIL b2b_second_done got=%b exp=1", done); end
        total++;
        next_cycle();
    endtask

    task automatic test_rst_in_run();
        load_pair(BW'($urandom), BW'($urandom));
        drive(0, 0, '0, 1); next_cycle();
        drive(0, 0, '0, 1); next_cycle();
        drive(1, 0, '0, 1);
        @(negedge clk);
        if ({m_valid, s_ready, CEB1, CEB2} !== 4'b0000) begin
            bad++; $display("FAIL rst_run_forced got=%b exp=0000", {m_valid, s_ready, CEB1, CEB2});
        end
        total++;
        next_cycle();
        drive(0, 0, '0, 1);
        @(negedge clk);
        if ({m_valid, inmode4, done, s_ready} !== 4'b0001) begin
            bad++; $display("FAIL rst_run_after got m_valid,inmode4,done,s_ready=%b exp=0001", {m_valid, inmode4, done, s_ready});
        end
        total++;
        next_cycle();
    endtask

`ifdef DUAL_B_ABORT_EN
    task automatic test_abort();
        load_pair(BW'($urandom), BW'($urandom));
        drive(0, 0, '0, 1); next_cycle();
        drive(0, 0, '0, 1); next_cycle();
        drive(0, 1, BW'($urandom), 1);
        abort = 1'b1;
        @(negedge clk);
        if ({s_ready, CEB1, CEB2} !== 3'b000) begin bad++; $display("FAIL abort_cycle got=%b exp=000", {s_ready, CEB1, CEB2}); end
        total++;
        next_cycle();
        abort = 1'b0;
        drive(0, 0, '0, 1);
        @(negedge clk);
        if ({m_valid, inmode4, done, s_ready} !== 4'b0001) begin
            bad++; $display("FAIL abort_after got m_valid,inmode4,done,s_ready=%b exp=0001", {m_valid, inmode4, done, s_ready});
        end
        total++;
        next_cycle();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 50) == 0, $urandom % 2, BW'($urandom), ($urandom % 4) != 0);
`ifdef DUAL_B_ABORT_EN
            abort = ($urandom % 30) == 0;
`endif
            next_cycle();
        end
        abort = 1'b0;
        drive(1, 0, '0, 0); next_cycle();
        drive(0, 0, '0, 0); next_cycle();
    endtask

    initial begin
        drive(1, 0, '0, 0);
        test_reset();
        test_basic();
        test_stall();
        test_load_gap();
        test_run_ignore();
        test_back_to_back();
        test_rst_in_run();
`ifdef DUAL_B_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
